// File: rtl/delay_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : delay_arbiter_if
// Brief    : Requester/timer handshake bundle for the shared delay arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface delay_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] ack;
    logic [NUM_REQ-1:0] err;
    logic [1:0]         grant_id;
    logic               busy;
    logic               timer_en;
    logic               timer_done;

    // master: requesters plus the timer; slave: the arbiter itself
    modport master (
        output req, timer_done,
        input  ack, err, grant_id, busy, timer_en
    );

    modport slave (
        input  req, timer_done,
        output ack, err, grant_id, busy, timer_en
    );
endinterface
`default_nettype wire

// File: rtl/delay_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : delay_arbiter
// Brief    : Round-robin sharing of one delay timer with a done watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module delay_arbiter #(
    parameter int          NUM_REQ = 4,
    parameter logic [25:0] TIMEOUT = 26'd50_000_100
) (
    input  wire logic        clk,
    input  wire logic        rst,
    delay_arbiter_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_ACK   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t             state_q;
    logic [1:0]         last_grant_q;
    logic [1:0]         grant_q;
    logic [1:0]         grant_d;
    logic [25:0]        wd_q;
    logic               timer_en_q;
    logic               busy_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [NUM_REQ-1:0] err_q;
    logic [1:0]         idx;
    logic               found;

    // Scan upward from the slot after the last grant; k == NUM_REQ wraps back
    // to last_grant itself, so a lone repeat requester is still served.
    always_comb begin
        grant_d = last_grant_q;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = last_grant_q + 2'(k);
            if (!found && bus.req[idx]) begin
                grant_d = idx;
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 2'd3;
            grant_q      <= 2'd0;
            wd_q         <= 26'd0;
            timer_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            ack_q        <= '0;
            err_q        <= '0;
        end else begin
            timer_en_q <= 1'b0;
            ack_q      <= '0;
            err_q      <= '0;
            case (state_q)
                S_IDLE: begin
                    if (|bus.req) begin
                        grant_q    <= grant_d;
                        timer_en_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd_q    <= 26'd0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // done wins over an expiring watchdog in the same cycle
                    if (bus.timer_done) begin
                        ack_q   <= NUM_REQ'(1) << grant_q;
                        state_q <= S_ACK;
                    end else if (wd_q == TIMEOUT - 26'd1) begin
                        err_q   <= NUM_REQ'(1) << grant_q;
                        state_q <= S_ERR;
                    end else begin
                        wd_q <= wd_q + 26'd1;
                    end
                end
                S_ACK, S_ERR: begin
                    last_grant_q <= grant_q;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = busy_q;
    assign bus.timer_en = timer_en_q;
endmodule
`default_nettype wire
